vga_adapter_core: RTL and testbench

// - Framebuffered VGA output stage. Pixel writes arrive on (x,y,colour,plot) in the system clock domain.
// - The block stores them in on-chip RAM and continuously scans out 640x480@60Hz.
// - Each stored pixel is replicated into a square block on screen. It sits between drawing logic and the DAC/connector pins.

---
 rtl/vga_adapter_core_if.sv | 24 ++
 rtl/vga_adapter_core.sv | 170 +++++++++++++++++
 tb/tb_vga_adapter_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_adapter_core_if.sv
// Pixel write bus into the VGA framebuffer: one (x, y, colour) write per plot strobe.
// Latency: not applicable (wires only).
// Backpressure: none; the framebuffer accepts a write on every clock.
//
// Signals:
//   colour  CW bits, packed {R,G,B} with R in the MSBs (or a single channel when monochrome)
//   x       column, XW bits
//   y       row, YW bits
//   plot    write strobe, sampled every clock
interface vga_adapter_core_if #(
  parameter int CW = 3,
  parameter int XW = 8,
  parameter int YW = 7
) ();
  logic [CW-1:0] colour;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          plot;

  // Drawing logic side.
  modport master (output colour, x, y, plot);
  // Framebuffer side.
  modport slave  (input  colour, x, y, plot);
endinterface

// File: rtl/vga_adapter_core.sv
// Framebuffered 640x480@60Hz VGA scan-out; each stored pixel is shown as an SxS block (S = 4 or 2).
// Latency: RGB/HS/VS/BLANK_N leave 2 pixel ticks after the scan counter value that produced them.
// Backpressure: none; a pixel write is accepted on any clock, out-of-range coordinates are dropped.
//
// Ports:
//   clock, reset        single 50 MHz clock, synchronous active-high reset
//   wr (slave)          pixel write bus: colour, x, y, plot
//   VGA_R/G/B           8-bit channel data, forced to 0 outside the visible region
//   VGA_HS, VGA_VS      active-low syncs
//   VGA_BLANK_N         high only in the visible region
//   VGA_SYNC_N          tied low
//   VGA_CLK             25 MHz pixel clock (the pixel-enable toggle)
// The framebuffer starts all black.
module vga_adapter_core #(
  parameter RESOLUTION = "160x120",
  parameter MONOCHROME = "FALSE",
  parameter int BITS_PER_COLOUR_CHANNEL = 1,
  parameter BACKGROUND_IMAGE = "black.mif"
) (
  input  logic              clock,
  input  logic              reset,
  vga_adapter_core_if.slave wr,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              VGA_SYNC_N,
  output logic              VGA_CLK
);

  localparam bit HI_RES = (RESOLUTION == "320x240");
  localparam int WIDTH  = HI_RES ? 320 : 160;
  localparam int HEIGHT = HI_RES ? 240 : 120;
  localparam int SH     = HI_RES ? 1 : 2;           // log2 of the replication factor
  localparam int XW     = HI_RES ? 9 : 8;
  localparam int YW     = HI_RES ? 8 : 7;
  localparam int BPC    = BITS_PER_COLOUR_CHANNEL;
  localparam bit MONO   = (MONOCHROME == "TRUE");
  localparam int CW     = MONO ? BPC : 3 * BPC;
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [XW-1:0] X_LIM = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(HEIGHT);

  // 640x480@60 timing, counted in pixel ticks / lines.
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd752;
  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd492;
  localparam logic [9:0] V_LAST    = 10'd524;

  // Replicate a BPC-bit channel MSB-first across 8 bits so full scale maps to 8'hFF.
  function automatic logic [7:0] expand(input logic [BPC-1:0] c);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e[7-i] = c[BPC-1-(i % BPC)];
    end
    return e;
  endfunction

  // ---------------------------------------------------------------- pixel enable / scan counters
  logic       pix_en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_en <= 1'b0;
      hcnt   <= '0;
      vcnt   <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;

  // Stage 0: decode of the current counter position.
  logic vis0, hs0, vs0;
  assign vis0 = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs0  = !((hcnt >= H_SYNC_LO) && (hcnt < H_SYNC_HI));
  assign vs0  = !((vcnt >= V_SYNC_LO) && (vcnt < V_SYNC_HI));

  // ---------------------------------------------------------------- framebuffer
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] rd_dat;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic          wr_en;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  assign wr_en   = wr.plot && !reset && (wr.x < X_LIM) && (wr.y < Y_LIM);
  assign wr_addr = AW'(wr.y) * AW'(WIDTH) + AW'(wr.x);
  // Only visible positions form a valid address; the read is skipped elsewhere.
  assign rd_addr = AW'(vcnt >> SH) * AW'(WIDTH) + AW'(hcnt >> SH);

  // Non-blocking read and write on the same edge give read-before-write on a collision:
  // the scan shows the old pixel and the new one appears on the next frame.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr.colour;
    end
    if (pix_en && vis0) begin
      rd_dat <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------- channel split
  logic [BPC-1:0] r1, g1, b1;

  if (MONO) begin : g_mono
    assign r1 = rd_dat;
    assign g1 = rd_dat;
    assign b1 = rd_dat;
  end else begin : g_rgb
    assign r1 = rd_dat[3*BPC-1:2*BPC];
    assign g1 = rd_dat[2*BPC-1:BPC];
    assign b1 = rd_dat[BPC-1:0];
  end

  // ---------------------------------------------------------------- stage 1 / stage 2 registers
  // Sync and blank ride alongside the RAM read so every output shares the 2-tick latency.
  logic vis1, hs1, vs1;

  always_ff @(posedge clock) begin
    if (reset) begin
      vis1        <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      vis1        <= vis0;
      hs1         <= hs0;
      vs1         <= vs0;
      VGA_HS      <= hs1;
      VGA_VS      <= vs1;
      VGA_BLANK_N <= vis1;
      VGA_R       <= vis1 ? expand(r1) : 8'h00;
      VGA_G       <= vis1 ? expand(g1) : 8'h00;
      VGA_B       <= vis1 ? expand(b1) : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_adapter_core.sv
// Directed bench for vga_adapter_core (160x120, 1 bit per channel, RGB).
// Every clock the pins are compared with a reference raster model; named screen points,
// per-line sync/blank counts and reset behaviour are checked against hand-computed values.
module tb_vga_adapter_core;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

  vga_adapter_core_if #(.CW(3), .XW(8), .YW(7)) wr_if ();

  vga_adapter_core dut (
    .clock       (clock),
    .reset       (reset),
    .wr          (wr_if),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .VGA_SYNC_N  (vga_sync_n),
    .VGA_CLK     (vga_clk)
  );

  always #10 clock = ~clock;

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
  } pt_t;

  int         checks;
  int         failures;
  int         c;            // clock edges since reset release (0 while in reset)
  int         hs_low;
  int         bl_hi;
  bit         phase_c;
  logic [2:0] mem_m [19200];
  pt_t        pts [12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference model, then compare outputs 1 time unit after the edge.
  task automatic step();
    int         q, h, v;
    logic [7:0] er, eg, eb;
    logic       ehs, evs, ebl, eclk;
    logic [2:0] p;
    @(posedge clock);
    #1;
    if (reset) c = 0;
    else c = c + 1;
    if (!reset && wr_if.plot && wr_if.x < 8'd160 && wr_if.y < 7'd120)
      mem_m[int'(wr_if.y) * 160 + int'(wr_if.x)] = wr_if.colour;

    eclk = (c % 2 == 1);
    er = 8'h00; eg = 8'h00; eb = 8'h00;
    ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
    h = 0; v = 0;
    // Ticks fall on even edges; the output shows the scan position two ticks old.
    q = c / 2 - 2;
    if (q >= 0) begin
      h   = q % 800;
      v   = (q / 800) % 525;
      ehs = !(h >= 656 && h < 752);
      evs = !(v >= 490 && v < 492);
      ebl = (h < 640) && (v < 480);
      if (ebl) begin
        p  = mem_m[(v / 4) * 160 + h / 4];
        er = {8{p[2]}};
        eg = {8{p[1]}};
        eb = {8{p[0]}};
      end
    end
    chk($sformatf("pins(c=%0d)", c),
        {3'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk},
        {3'b0, er, eg, eb, ehs, evs, ebl, 1'b0, eclk});

    if (q < 0) begin
      hs_low = 0;
      bl_hi  = 0;
    end else if (c % 2 == 0) begin
      if (!vga_hs) hs_low++;
      if (vga_blank_n) bl_hi++;
      if (h == 799) begin
        chk($sformatf("hs_low_ticks(line %0d)", v), hs_low, 96);
        chk($sformatf("blank_hi_ticks(line %0d)", v), bl_hi, 640);
        hs_low = 0;
        bl_hi  = 0;
      end
      if (phase_c) begin
        for (int i = 0; i < 12; i++) begin
          if (pts[i].h == h && pts[i].v == v)
            chk($sformatf("pix(%0d,%0d)", h, v), {8'h0, vga_r, vga_g, vga_b}, {8'h0, pts[i].rgb});
        end
      end
    end
  endtask

  task automatic do_plot(input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] col);
    wr_if.x      = xx;
    wr_if.y      = yy;
    wr_if.colour = col;
    wr_if.plot   = 1'b1;
    step();
    wr_if.plot   = 1'b0;
  endtask

  initial begin
    int  guard;
    bit  found;
    checks   = 0;
    failures = 0;
    c        = 0;
    hs_low   = 0;
    bl_hi    = 0;
    phase_c  = 1'b0;
    for (int i = 0; i < 19200; i++) mem_m[i] = 3'b000;

    pts[0]  = '{0,   0, 24'hFF0000};   // written red pixel, top-left corner
    pts[1]  = '{3,   3, 24'hFF0000};   // far corner of its 4x4 block
    pts[2]  = '{4,   0, 24'h000000};   // neighbour block untouched
    pts[3]  = '{636, 0, 24'hFFFFFF};   // x=159 white block, right edge
    pts[4]  = '{639, 3, 24'hFFFFFF};
    pts[5]  = '{635, 3, 24'h000000};
    pts[6]  = '{20,  4, 24'h00FF00};   // (5,1) green
    pts[7]  = '{23,  7, 24'h00FF00};
    pts[8]  = '{0,   4, 24'h000000};   // where x=160,y=0 would alias
    pts[9]  = '{380, 4, 24'h000000};   // where x=255,y=0 would alias
    pts[10] = '{160, 8, 24'h000000};   // where x=200,y=1 would alias
    pts[11] = '{640, 0, 24'h000000};   // first blanked tick of line 0

    wr_if.x      = '0;
    wr_if.y      = '0;
    wr_if.colour = '0;
    wr_if.plot   = 1'b0;

    // Reset for 5 clocks; pins must hold their reset values.
    reset = 1'b1;
    repeat (5) step();
    chk("reset_sync_n", {31'b0, vga_sync_n}, 32'd0);
    chk("reset_hs_vs", {30'b0, vga_hs, vga_vs}, 32'd3);
    chk("reset_blank_rgb", {7'b0, vga_blank_n, vga_r, vga_g, vga_b}, 32'd0);
    reset = 1'b0;

    // First 8 lines of the first frame: all black.
    repeat (2 * 800 * 8 + 10) step();

    // Writes land on rows 0/1 while the scan is on row 2, so no read collides with them.
    do_plot(8'd0,   7'd0,   3'b100);
    do_plot(8'd159, 7'd0,   3'b111);
    do_plot(8'd5,   7'd1,   3'b010);
    do_plot(8'd160, 7'd0,   3'b111);
    do_plot(8'd255, 7'd0,   3'b111);
    do_plot(8'd200, 7'd1,   3'b111);
    do_plot(8'd0,   7'd120, 3'b111);
    do_plot(8'd159, 7'd119, 3'b111);

    // Advance until the horizontal counter sits at 300, then reset for one clock.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 4000) begin
      if (c % 2 == 0 && (c / 2) % 800 == 300) found = 1'b1;
      else begin
        step();
        guard++;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL midline_wait observed=timeout expected=hcnt300");
    end
    reset = 1'b1;
    step();
    chk("midline_rst_hs_vs", {30'b0, vga_hs, vga_vs}, 32'd3);
    chk("midline_rst_blank_rgb", {7'b0, vga_blank_n, vga_r, vga_g, vga_b}, 32'd0);
    chk("midline_rst_vga_clk", {31'b0, vga_clk}, 32'd0);
    reset = 1'b0;

    // Scan restarts at (0,0); the pixels written before reset must still be shown.
    phase_c = 1'b1;
    repeat (2 * 800 * 14 + 8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
